demo_de0_sys_ram_arbiter: RTL and testbench
===========================================

// Module: demo_de0_sys_ram_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the on-chip single-port RAM (2048x32, byte enables, 1-cycle read).
//  Shares the RAM between the Nios data master (m0) and the decoder DMA master (m1).
//  Each side is an Avalon-MM slave port with waitrequest and readdatavalid.
//  Drives the RAM's address/byteenable/chipselect/write/writedata/clken pins.
// PARAMETERS
//  ADDR_W    11   word address width (2048 words)
//  DATA_W    32   data width; BE_W = DATA_W/8 derived locally
//  LOCK_MAX  16   max consecutive grants a locked master may hold (RAM_ARB_LOCK_EN only); range 1..255
// PORTS
//  clk               in   1       system clock
//  reset             in   1       asynchronous, active-high reset
//  mN_address        in   ADDR_W  word address, N = 0,1
//  mN_read           in   1       read request
//  mN_write          in   1       write request
//  mN_byteenable     in   BE_W    write byte lanes
//  mN_writedata      in   DATA_W  write data
//  mN_lock           in   1       hold grant (present only with RAM_ARB_LOCK_EN)
//  mN_waitrequest    out  1       command not accepted this cycle
//  mN_readdata       out  DATA_W  read data, valid when mN_readdatavalid
//  mN_readdatavalid  out  1       read data valid strobe
//  ram_address       out  ADDR_W  to RAM address
//  ram_byteenable    out  BE_W    to RAM byteenable
//  ram_chipselect    out  1       to RAM chipselect
//  ram_write         out  1       to RAM write
//  ram_writedata     out  DATA_W  to RAM writedata
//  ram_clken         out  1       to RAM clken, constant 1
//  ram_readdata      in   DATA_W  from RAM readdata (valid the cycle after address)
// BEHAVIOUR
//  - reqN = mN_read | mN_write. Grant is combinational, one master per cycle; a granted command is accepted that edge.
//  - mN_waitrequest = reqN & ~grantN; zero when idle. No added latency: grant in same cycle as request.
//  - Round-robin: last_grant register (reset 1 -> m0 has priority first). Both requesting -> the master
//    not in last_grant wins. Single requester always wins. last_grant updates only on an accepted command.
//  - RAM mux: ram_* follow granted master; ram_chipselect = any grant; ram_write = granted write.
//    No grant -> chipselect=0, write=0, address/data hold last value (don't care).
//  - mN_read & mN_write together: write wins, read dropped, no readdatavalid. Treated as master protocol error.
//  - Read latency exactly 1: accepted read at edge k -> rvN register set, mN_readdatavalid high in cycle k+1,
//    mN_readdata = ram_readdata (combinational pass-through). Both readdata ports carry ram_readdata;
//    only the owner's valid strobe asserts. Back-to-back reads give one valid per cycle.
//  - Writes: no response; RAM updated at accepting edge. Read-after-write to same address from either master
//    in the next cycle returns the new data.
//  - Reset (async, any time): last_grant=1, rv0=rv1=0, lock state cleared; in-flight read returns no valid.
//    All outputs combinationally derived from inputs are 0 while reset with no requests; ram_clken=1 always.
// CONFIGURATION
//  RAM_ARB_LOCK_EN defined: mN_lock ports exist. A master accepted with mN_lock=1 keeps priority on following
//    cycles while lock stays high, even if the other requests; counter lock_cnt increments per locked grant.
//    At lock_cnt==LOCK_MAX, or on the first cycle the holder's lock or request drops, priority reverts to
//    round-robin and lock_cnt clears. Lock from the non-granted master is ignored until it is granted.
//  RAM_ARB_LOCK_EN undefined: no lock ports, no counter; pure round-robin as above.
// TESTING
//  1. m0 read addr 0x010 alone, RAM word 0x11223344 -> waitrequest 0, m0_readdatavalid next cycle, data 0x11223344.
//  2. m0 and m1 read every cycle for 8 cycles from reset -> grants m0,m1,m0,...; each waitrequest high alternate cycles.
//  3. m1 write 0xDEADBEEF BE=4'b0011 addr 0x7FF, then m0 read 0x7FF -> low half 0xBEEF, upper half unchanged.
//  4. Read accepted, reset asserted before next edge -> no readdatavalid; after release m0 wins first contention.
//  5. LOCK_EN, LOCK_MAX=4: m1 locked and m0 requesting continuously -> m1 granted 4 cycles, then m0 granted.
//  6. m0 asserts read+write to 0x020 -> RAM written, no m0_readdatavalid issued.

Source files
------------

// File: rtl/demo_de0_sys_ram_arbiter_if.sv
// demo_de0_sys_ram_arbiter_if: one Avalon-MM port into the RAM arbiter; lock exists only with RAM_ARB_LOCK_EN
interface demo_de0_sys_ram_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;
  logic [ADDR_W-1:0] address;
  logic read;
  logic write;
  logic [BE_W-1:0] byteenable;
  logic [DATA_W-1:0] writedata;
`ifdef RAM_ARB_LOCK_EN
  logic lock;
`endif
  logic waitrequest;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  modport master (
    output address, read, write, byteenable, writedata,
`ifdef RAM_ARB_LOCK_EN
    output lock,
`endif
    input waitrequest, readdata, readdatavalid
  );
  modport slave (
    input address, read, write, byteenable, writedata,
`ifdef RAM_ARB_LOCK_EN
    input lock,
`endif
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/demo_de0_sys_ram_arbiter.sv
// demo_de0_sys_ram_arbiter: two-master round-robin arbiter for a 1-cycle-read single-port RAM
// Optional RAM_ARB_LOCK_EN lets a granted master hold the RAM for up to LOCK_MAX grants.
module demo_de0_sys_ram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int LOCK_MAX = 16,
  localparam int BE_W = DATA_W / 8
) (
  input  logic clk,
  input  logic reset,
  demo_de0_sys_ram_arbiter_if.slave m0,
  demo_de0_sys_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0] ram_byteenable,
  output logic ram_chipselect,
  output logic ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic ram_clken,
  input  logic [DATA_W-1:0] ram_readdata
);
  logic req0, req1, grant0, grant1, pri0, last_grant, rv0, rv1;
  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;
`ifdef RAM_ARB_LOCK_EN
  logic lock_act, lock_who, lock_g, hold;
  logic [7:0] lock_cnt, cnt_n;
  // holder keeps priority only while both its request and lock stay high
  assign hold = lock_act & (lock_who ? req1 & m1.lock : req0 & m0.lock);
  assign pri0 = hold ? ~lock_who : last_grant;
  assign lock_g = (grant0 & m0.lock) | (grant1 & m1.lock);
  assign cnt_n = ((lock_act && lock_who == grant1) ? lock_cnt : 8'd0) + 8'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lock_act <= 1'b0;
      lock_who <= 1'b0;
      lock_cnt <= 8'd0;
    end else begin
      lock_act <= lock_g && cnt_n != 8'(LOCK_MAX);
      lock_who <= grant1;
      lock_cnt <= (lock_g && cnt_n != 8'(LOCK_MAX)) ? cnt_n : 8'd0;
    end
`else
  assign pri0 = last_grant;
`endif
  assign grant0 = req0 & (~req1 | pri0);
  assign grant1 = req1 & ~grant0;
  assign m0.waitrequest = req0 & ~grant0;
  assign m1.waitrequest = req1 & ~grant1;
  assign ram_address = grant1 ? m1.address : m0.address;
  assign ram_byteenable = grant1 ? m1.byteenable : m0.byteenable;
  assign ram_writedata = grant1 ? m1.writedata : m0.writedata;
  assign ram_chipselect = grant0 | grant1;
  assign ram_write = (grant0 & m0.write) | (grant1 & m1.write);
  assign ram_clken = 1'b1;
  assign m0.readdata = ram_readdata;
  assign m1.readdata = ram_readdata;
  assign m0.readdatavalid = rv0;
  assign m1.readdatavalid = rv1;
  // read+write together is a protocol error: the write proceeds, the read gets no response
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_grant <= 1'b1;
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      last_grant <= (grant0 | grant1) ? grant1 : last_grant;
      rv0 <= grant0 & m0.read & ~m0.write;
      rv1 <= grant1 & m1.read & ~m1.write;
    end
endmodule

// File: tb/tb_demo_de0_sys_ram_arbiter.sv
// tb_demo_de0_sys_ram_arbiter: directed scoreboard bench with a behavioural 1-cycle RAM
module tb_demo_de0_sys_ram_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  demo_de0_sys_ram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) m0 ();
  demo_de0_sys_ram_arbiter_if #(.ADDR_W(11), .DATA_W(32)) m1 ();
  logic [10:0] ram_address;
  logic [3:0] ram_byteenable;
  logic ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
  demo_de0_sys_ram_arbiter #(.ADDR_W(11), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset), .m0(m0), .m1(m1),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );
  logic [31:0] mem [0:2047];
  always @(posedge clk)
    if (ram_chipselect) begin
      ram_readdata = mem[ram_address];
      if (ram_write)
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
    end
  typedef struct {logic w0; logic w1;} wexp_t;
  wexp_t wq[$];
  wexp_t we;
  logic [31:0] rq0[$], rq1[$];
  int vectors = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (m0.read | m0.write | m1.read | m1.write) begin
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL wait_queue: request seen with no expectation at %0t", $time);
      end else begin
        we = wq.pop_front();
        check("m0_waitrequest", 32'(m0.waitrequest), 32'(we.w0));
        check("m1_waitrequest", 32'(m1.waitrequest), 32'(we.w1));
      end
    end else check("idle_waitrequest", {30'd0, m1.waitrequest, m0.waitrequest}, 32'd0);
    if (m0.readdatavalid) begin
      if (rq0.size() == 0) begin
        errors++;
        $display("FAIL m0_readdatavalid: unexpected strobe, got 1 expected 0 at %0t", $time);
      end else check("m0_readdata", m0.readdata, rq0.pop_front());
    end
    if (m1.readdatavalid) begin
      if (rq1.size() == 0) begin
        errors++;
        $display("FAIL m1_readdatavalid: unexpected strobe, got 1 expected 0 at %0t", $time);
      end else check("m1_readdata", m1.readdata, rq1.pop_front());
    end
  end
  task automatic set(input bit m, input logic r, input logic w, input logic [10:0] a,
                     input logic [3:0] be, input logic [31:0] d);
    if (!m) begin
      m0.read = r; m0.write = w; m0.address = a; m0.byteenable = be; m0.writedata = d;
    end else begin
      m1.read = r; m1.write = w; m1.address = a; m1.byteenable = be; m1.writedata = d;
    end
  endtask
  task automatic idle();
    set(0, 0, 0, 11'd0, 4'd0, 32'd0);
    set(1, 0, 0, 11'd0, 4'd0, 32'd0);
  endtask
  task automatic tick(input logic ew0, input logic ew1, input logic [31:0] ed0, input logic [31:0] ed1);
    if (m0.read | m0.write | m1.read | m1.write) wq.push_back('{ew0, ew1});
    if (m0.read & ~m0.write & ~ew0) rq0.push_back(ed0);
    if (m1.read & ~m1.write & ~ew1) rq1.push_back(ed1);
    @(posedge clk);
    #1 idle();
  endtask
  initial begin
    idle();
`ifdef RAM_ARB_LOCK_EN
    m0.lock = 1'b0;
    m1.lock = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) mem[i] = 32'hA5000000 | i;
    mem[16] = 32'h11223344;
    mem[2047] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_clken", 32'(ram_clken), 32'd1);
    check("rst_chipselect", 32'(ram_chipselect), 32'd0);
    check("rst_write", 32'(ram_write), 32'd0);
    check("rst_rdv", {30'd0, m1.readdatavalid, m0.readdatavalid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set(0, 1, 0, 11'h010, 4'hF, 32'd0);
      set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
      tick(i[0], ~i[0], 32'h11223344, 32'hCAFEF00D);
    end
    set(0, 1, 0, 11'h010, 4'hF, 32'd0);
    tick(0, 0, 32'h11223344, 32'd0);
    set(1, 0, 1, 11'h7FF, 4'b0011, 32'hDEADBEEF);
    tick(0, 0, 32'd0, 32'd0);
    set(0, 1, 0, 11'h7FF, 4'hF, 32'd0);
    tick(0, 0, 32'hCAFEBEEF, 32'd0);
    set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
    tick(0, 0, 32'd0, 32'hCAFEBEEF);
    set(0, 1, 1, 11'h020, 4'hF, 32'h12345678);
    tick(0, 0, 32'd0, 32'd0);
    set(0, 1, 0, 11'h020, 4'hF, 32'd0);
    tick(0, 0, 32'h12345678, 32'd0);
    set(0, 1, 0, 11'h010, 4'hF, 32'd0);
    wq.push_back('{1'b0, 1'b0});
    @(posedge clk);
    #1 reset = 1'b1;
    idle();
    @(negedge clk);
    check("rst_inflight_rdv", 32'(m0.readdatavalid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    set(0, 1, 0, 11'h010, 4'hF, 32'd0);
    set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
    tick(0, 1, 32'h11223344, 32'd0);
    set(0, 1, 0, 11'h010, 4'hF, 32'd0);
    set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
    tick(1, 0, 32'd0, 32'hCAFEBEEF);
`ifdef RAM_ARB_LOCK_EN
    m1.lock = 1'b1;
    set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
    tick(0, 0, 32'd0, 32'hCAFEBEEF);
    for (int j = 0; j < 3; j++) begin
      set(0, 1, 0, 11'h010, 4'hF, 32'd0);
      set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
      tick(1, 0, 32'd0, 32'hCAFEBEEF);
    end
    set(0, 1, 0, 11'h010, 4'hF, 32'd0);
    set(1, 1, 0, 11'h7FF, 4'hF, 32'd0);
    tick(0, 1, 32'h11223344, 32'd0);
    m1.lock = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rq0_drained", 32'(rq0.size()), 32'd0);
    check("rq1_drained", 32'(rq1.size()), 32'd0);
    check("wq_drained", 32'(wq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
